// File: rtl/pulse_sequencer.sv
// Pulse sequencer: runs P1 -> D1 -> P2 -> ACQ frames, rep_cfg times, driving DDS tuning/phase and TX/RX gates.
// Ports: start/abort control, frq_cfg/p*_len/acq_len/p2_phase/rep_cfg program (latched on start),
//        frq/phase to the DDS, tx_gate/rx_gate, busy/done status, rep_idx current repetition.
//
// The segment FSM runs one cycle ahead of the output registers: at the accepting edge the FSM
// already enters the first non-empty segment while the outputs show a single launch cycle
// (busy=1, gates low). Every output is therefore a flop fed from the current FSM state.

module pulse_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      frq_cfg,
  input  logic [CNT_W-1:0] p1_len,
  input  logic [CNT_W-1:0] d1_len,
  input  logic [CNT_W-1:0] p2_len,
  input  logic [CNT_W-1:0] acq_len,
  input  logic [1:0]       p2_phase,
  input  logic [15:0]      rep_cfg,
  output logic [31:0]      frq,
  output logic [1:0]       phase,
  output logic             tx_gate,
  output logic             rx_gate,
  output logic             busy,
  output logic             done,
  output logic [15:0]      rep_idx
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    D1   = 3'd2,
    P2   = 3'd3,
    ACQ  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Segment index 0..3 maps onto P1, D1, P2, ACQ.
  function automatic state_t seg_state(input logic [1:0] idx);
    case (idx)
      2'd0:    return P1;
      2'd1:    return D1;
      2'd2:    return P2;
      default: return ACQ;
    endcase
  endfunction

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [3:0][CNT_W-1:0]   len_l, len_in, len_src;
  logic [15:0]             rep_l, rep_src, rep_eff, rep_cur;
  logic [15:0]             rep_int, rep_nxt;
  logic [1:0]              ph_l;
  logic                    fin, fin_nxt;
  logic                    accept, seg_end, more_reps;
  logic                    found_a, found_b;
  logic [1:0]              idx_a, idx_b;
  logic [2:0]              from_idx;

  logic [31:0]             frq_nxt;
  logic [1:0]              phase_nxt;
  logic                    tx_nxt, rx_nxt, busy_nxt, done_nxt;
  logic [15:0]             rep_idx_nxt;

  assign len_in = {acq_len, p2_len, d1_len, p1_len};

  always_comb begin
    // busy covers the launch cycle and the done cycle's predecessor, where the FSM is already IDLE.
    accept    = (state == IDLE) && !busy && start && !abort;
    len_src   = accept ? len_in : len_l;
    rep_src   = accept ? rep_cfg : rep_l;
    rep_eff   = (rep_src == 16'd0) ? 16'd1 : rep_src;
    rep_cur   = accept ? 16'd0 : rep_int;
    more_reps = ({1'b0, rep_cur} + 17'd1) < {1'b0, rep_eff};
    seg_end   = (state != IDLE) && (cnt == ONE);

    case (state)
      P1:      from_idx = 3'd1;
      D1:      from_idx = 3'd2;
      P2:      from_idx = 3'd3;
      ACQ:     from_idx = 3'd4;
      default: from_idx = 3'd0;
    endcase

    // found_a: next non-empty segment later in this frame; found_b: first non-empty segment of a frame.
    found_a = 1'b0;
    idx_a   = 2'd0;
    found_b = 1'b0;
    idx_b   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (len_src[i] != '0) begin
        if (3'(i) >= from_idx) begin
          found_a = 1'b1;
          idx_a   = 2'(i);
        end
        found_b = 1'b1;
        idx_b   = 2'(i);
      end
    end

    state_nxt = state;
    cnt_nxt   = cnt;
    rep_nxt   = accept ? 16'd0 : rep_int;
    fin_nxt   = 1'b0;

    if (state != IDLE && !seg_end) begin
      cnt_nxt = cnt - ONE;
    end

    // Empty segments are skipped within the same edge, so no idle cycle appears between segments.
    if (accept || seg_end) begin
      if (found_a) begin
        state_nxt = seg_state(idx_a);
        cnt_nxt   = len_src[idx_a];
      end else if (!accept && more_reps && found_b) begin
        state_nxt = seg_state(idx_b);
        cnt_nxt   = len_src[idx_b];
        rep_nxt   = rep_int + 16'd1;
      end else begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        fin_nxt   = 1'b1;
      end
    end

    // Output stage reflects the state the FSM held during this cycle.
    tx_nxt      = (state == P1) || (state == P2);
    rx_nxt      = (state == ACQ);
    busy_nxt    = (state != IDLE) || accept;
    done_nxt    = fin;
    frq_nxt     = accept ? frq_cfg : frq;
    rep_idx_nxt = accept ? 16'd0 : rep_int;
    phase_nxt   = phase;
    if (state == P1) begin
      phase_nxt = 2'b00;
    end else if (state == P2) begin
      phase_nxt = ph_l;
    end

    // Abort wins over everything; rep_int is resynchronised to the visible index so it holds in IDLE.
    if (abort) begin
      state_nxt   = IDLE;
      cnt_nxt     = '0;
      fin_nxt     = 1'b0;
      rep_nxt     = rep_idx;
      tx_nxt      = 1'b0;
      rx_nxt      = 1'b0;
      busy_nxt    = 1'b0;
      done_nxt    = 1'b0;
      rep_idx_nxt = rep_idx;
      phase_nxt   = phase;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rep_int <= '0;
      fin     <= 1'b0;
      len_l   <= '0;
      rep_l   <= '0;
      ph_l    <= '0;
      frq     <= '0;
      phase   <= '0;
      tx_gate <= 1'b0;
      rx_gate <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rep_idx <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rep_int <= rep_nxt;
      fin     <= fin_nxt;
      if (accept) begin
        len_l <= len_in;
        rep_l <= rep_cfg;
        ph_l  <= p2_phase;
      end
      frq     <= frq_nxt;
      phase   <= phase_nxt;
      tx_gate <= tx_nxt;
      rx_gate <= rx_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      rep_idx <= rep_idx_nxt;
    end
  end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Bench for pulse_sequencer: per-cycle expected output vectors are queued when a run is launched
// and popped/compared on every falling edge.

module tb_pulse_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] frq_cfg;
  logic [31:0] p1_len, d1_len, p2_len, acq_len;
  logic [1:0]  p2_phase;
  logic [15:0] rep_cfg;
  logic [31:0] frq;
  logic [1:0]  phase;
  logic        tx_gate, rx_gate, busy, done;
  logic [15:0] rep_idx;

  always #5 clk = ~clk;

  pulse_sequencer #(.CNT_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .frq_cfg  (frq_cfg),
    .p1_len   (p1_len),
    .d1_len   (d1_len),
    .p2_len   (p2_len),
    .acq_len  (acq_len),
    .p2_phase (p2_phase),
    .rep_cfg  (rep_cfg),
    .frq      (frq),
    .phase    (phase),
    .tx_gate  (tx_gate),
    .rx_gate  (rx_gate),
    .busy     (busy),
    .done     (done),
    .rep_idx  (rep_idx)
  );

  typedef struct packed {
    logic        tx;
    logic        rx;
    logic        busy;
    logic        done;
    logic [1:0]  phase;
    logic [15:0] rep;
    logic [31:0] frq;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [1:0]  m_phase;
  logic [15:0] m_rep;
  logic [31:0] m_frq;

  function automatic exp_t observe();
    exp_t o;
    o.tx    = tx_gate;
    o.rx    = rx_gate;
    o.busy  = busy;
    o.done  = done;
    o.phase = phase;
    o.rep   = rep_idx;
    o.frq   = frq;
    return o;
  endfunction

  // Expected behaviour of one run, cycle 0 being the launch cycle right after the start edge.
  task automatic model_run(input int p1, input int d1, input int p2, input int acq, input int rep,
                           input logic [1:0] ph, input logic [31:0] f, input int abort_at, input int tail);
    int   frame, reps, last, done_c, fi, o;
    exp_t e;
    frame  = p1 + d1 + p2 + acq;
    reps   = (rep == 0) ? 1 : rep;
    last   = (frame == 0) ? 0 : reps * frame;
    done_c = last + 1;
    m_frq  = f;
    for (int c = 0; c <= done_c + tail; c++) begin
      e = '0;
      if (abort_at >= 0 && c > abort_at) begin
        e.busy = 1'b0;
      end else if (c == 0) begin
        e.busy = 1'b1;
        m_rep  = 16'd0;
      end else if (c <= last) begin
        fi     = (c - 1) / frame;
        o      = (c - 1) % frame;
        m_rep  = 16'(fi);
        e.busy = 1'b1;
        if (o < p1) begin
          e.tx    = 1'b1;
          m_phase = 2'b00;
        end else if (o < p1 + d1) begin
          e.tx = 1'b0;
        end else if (o < p1 + d1 + p2) begin
          e.tx    = 1'b1;
          m_phase = ph;
        end else begin
          e.rx = 1'b1;
        end
      end else if (c == done_c) begin
        e.done = 1'b1;
      end
      e.phase = m_phase;
      e.rep   = m_rep;
      e.frq   = m_frq;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_run(input string name, input int p1, input int d1, input int p2, input int acq,
                           input int rep, input logic [1:0] ph, input logic [31:0] f,
                           input int abort_at, input int poke_at, input int tail);
    exp_t e, o;
    int   n;
    p1_len   = 32'(p1);
    d1_len   = 32'(d1);
    p2_len   = 32'(p2);
    acq_len  = 32'(acq);
    rep_cfg  = 16'(rep);
    p2_phase = ph;
    frq_cfg  = f;
    start    = 1'b1;
    model_run(p1, d1, p2, acq, rep, ph, f, abort_at, tail);
    n = exp_q.size();
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      e = exp_q.pop_front();
      o = observe();
      n_chk++;
      if (o !== e) begin
        $display("FAIL %s cycle %0d: got tx=%b rx=%b busy=%b done=%b ph=%b rep=%0d frq=%h, expected tx=%b rx=%b busy=%b done=%b ph=%b rep=%0d frq=%h",
                 name, c, o.tx, o.rx, o.busy, o.done, o.phase, o.rep, o.frq,
                 e.tx, e.rx, e.busy, e.done, e.phase, e.rep, e.frq);
      end else begin
        n_pass++;
      end
      if (c == abort_at) abort = 1'b1;
      if (c == poke_at) begin
        start    = 1'b1;
        frq_cfg  = ~f;
        p1_len   = 32'd1;
        d1_len   = 32'd0;
        p2_len   = 32'd1;
        acq_len  = 32'd1;
        rep_cfg  = 16'd5;
        p2_phase = ~ph;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0; frq_cfg = 32'h1234_5678;
    p1_len = 32'd1; d1_len = 32'd1; p2_len = 32'd1; acq_len = 32'd1;
    p2_phase = 2'b11; rep_cfg = 16'd1;
    #2 rst = 1'b1;
    #1;
    n_chk++; if (tx_gate !== 1'b0) $display("FAIL reset_tx: got %b expected 0", tx_gate); else n_pass++;
    n_chk++; if (rx_gate !== 1'b0) $display("FAIL reset_rx: got %b expected 0", rx_gate); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
    n_chk++; if (frq !== 32'd0) $display("FAIL reset_frq: got %h expected 0", frq); else n_pass++;
    n_chk++; if (phase !== 2'd0) $display("FAIL reset_phase: got %b expected 0", phase); else n_pass++;
    n_chk++; if (rep_idx !== 16'd0) $display("FAIL reset_rep_idx: got %0d expected 0", rep_idx); else n_pass++;
    start = 1'b1;
    @(posedge clk);
    #1;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_start_held: busy got %b expected 0", busy); else n_pass++;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_phase = 2'b00; m_rep = 16'd0; m_frq = 32'd0;
  endtask

  task automatic test_abort_start();
    exp_t e, o;
    frq_cfg = 32'hDEAD_BEEF; p1_len = 32'd3; d1_len = 32'd0; p2_len = 32'd2; acq_len = 32'd2;
    rep_cfg = 16'd1; start = 1'b1; abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = '0; e.phase = m_phase; e.rep = m_rep; e.frq = m_frq;
      exp_q.push_back(e);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      e = exp_q.pop_front();
      o = observe();
      n_chk++;
      if (o !== e) $display("FAIL abort_start cycle %0d: got busy=%b tx=%b frq=%h, expected busy=%b tx=%b frq=%h",
                            c, o.busy, o.tx, o.frq, e.busy, e.tx, e.frq);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    exp_t o;
    p1_len = 32'd4; d1_len = 32'd10; p2_len = 32'd8; acq_len = 32'd20;
    rep_cfg = 16'd1; p2_phase = 2'b01; frq_cfg = 32'h0BAD_F00D; start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 9) begin
        n_chk++;
        if (busy !== 1'b1 || tx_gate !== 1'b0) $display("FAIL reset_mid_pre: got busy=%b tx=%b expected busy=1 tx=0", busy, tx_gate);
        else n_pass++;
      end
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    o = observe();
    n_chk++;
    if (o !== '0) $display("FAIL reset_mid_async: got tx=%b rx=%b busy=%b done=%b ph=%b rep=%0d frq=%h expected all zero",
                           o.tx, o.rx, o.busy, o.done, o.phase, o.rep, o.frq);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    m_phase = 2'b00; m_rep = 16'd0; m_frq = 32'd0;
    drive_run("reset_mid_restart", 2, 1, 2, 3, 2, 2'b10, 32'h7777_0001, -1, -1, 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    drive_run("basic",           4, 10, 8, 20, 1, 2'b01, 32'hA5A5_0001, -1, -1, 3);
    drive_run("reps",            4, 10, 8, 20, 3, 2'b01, 32'hA5A5_0002, -1, -1, 3);
    drive_run("d1_zero",         3, 0,  5, 6,  2, 2'b10, 32'h0000_1003, -1, -1, 2);
    drive_run("zero_len",        0, 0,  0, 0,  3, 2'b11, 32'h0000_1004, -1, -1, 2);
    drive_run("rep_zero",        2, 1,  2, 3,  0, 2'b11, 32'h0000_1005, -1, -1, 2);
    drive_run("skip_mixed",      0, 2,  0, 3,  2, 2'b01, 32'h0000_1006, -1, -1, 2);
    drive_run("abort_acq",       4, 10, 8, 20, 1, 2'b01, 32'hA5A5_0007, 30, -1, 3);
    drive_run("restart_ignored", 4, 10, 8, 20, 1, 2'b10, 32'hA5A5_0008, -1, 12, 2);
    for (int i = 0; i < 5; i++) begin
      drive_run("back_to_back", int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), $urandom, -1, -1, 0);
    end
    drive_run("back_to_back_end", 1, 1, 1, 1, 1, 2'b01, 32'h0000_2000, -1, -1, 2);
    test_abort_start();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
